// File: rtl/regfile_wb_arbiter.sv
// Round-robin write-back arbiter for the vector register file plus a per-register busy scoreboard.
// The scoreboard is built only when RF_WB_SCOREBOARD_EN is defined; otherwise busy=0 and claim_ready=1.
module regfile_wb_arbiter #(
    parameter int NUM_REQ    = 3,
    parameter int DATA_WIDTH = 512,
    parameter int ADDR_WIDTH = 5,
    parameter int DEPTH      = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic                          rf_wen,
    output logic [ADDR_WIDTH-1:0]         rf_addr_w,
    output logic [DATA_WIDTH-1:0]         rf_data_w,
    input  logic                          claim_valid,
    input  logic [ADDR_WIDTH-1:0]         claim_addr,
    output logic                          claim_ready,
    output logic [DEPTH-1:0]              busy
);

    localparam int PTR_W = (NUM_REQ > 2) ? 2 : 1;

    // Handshake: requester i transfers on a cycle where req_valid[i] & req_ready[i].
    // req_ready is one-hot or zero and only ever follows an asserted req_valid.
    logic [PTR_W-1:0]      ptr;
    logic [PTR_W-1:0]      ptr_next;
    logic [NUM_REQ-1:0]    grant;
    logic                  found;
    logic [PTR_W:0]        sum;
    logic [PTR_W-1:0]      idx;
    logic                  hs;
    logic [ADDR_WIDTH-1:0] wb_addr;
    logic [DATA_WIDTH-1:0] wb_data;

    always_comb begin
        grant = '0;
        found = 1'b0;
        sum   = '0;
        idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, ptr} + (PTR_W+1)'(k);
            if (sum >= (PTR_W+1)'(NUM_REQ))
                sum = sum - (PTR_W+1)'(NUM_REQ);
            idx = sum[PTR_W-1:0];
            if (!found && req_valid[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

    assign req_ready = rst ? '0 : grant;
    assign hs        = |req_ready;

    always_comb begin
        wb_addr  = '0;
        wb_data  = '0;
        ptr_next = ptr;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (req_ready[k]) begin
                wb_addr  = req_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
                wb_data  = req_data[k*DATA_WIDTH +: DATA_WIDTH];
                ptr_next = (k == NUM_REQ-1) ? '0 : PTR_W'(k + 1);
            end
        end
    end

    // Address and data hold between writes; only rf_wen pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            rf_wen    <= 1'b0;
            rf_addr_w <= '0;
            rf_data_w <= '0;
            ptr       <= '0;
        end else begin
            rf_wen <= hs;
            ptr    <= ptr_next;
            if (hs) begin
                rf_addr_w <= wb_addr;
                rf_data_w <= wb_data;
            end
        end
    end

`ifdef RF_WB_SCOREBOARD_EN
    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_next;

    assign claim_ready = rst ? 1'b0 : ~busy_q[claim_addr];
    assign busy        = busy_q;

    // Clear first, then set, so a same-cycle claim of the written register wins.
    always_comb begin
        busy_next = busy_q;
        if (hs)
            busy_next[wb_addr] = 1'b0;
        if (claim_valid && claim_ready)
            busy_next[claim_addr] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst)
            busy_q <= '0;
        else
            busy_q <= busy_next;
    end
`else
    logic unused_claim;
    assign unused_claim = ^{claim_valid, claim_addr};
    assign claim_ready  = 1'b1;
    assign busy         = '0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios plus a randomized run
// checked against a spec-level model (modular round-robin search, busy bit array, expected write queue).
module tb_regfile_wb_arbiter;

    localparam int NR = 3;
    localparam int DW = 512;
    localparam int AW = 5;
    localparam int DP = 32;
`ifdef RF_WB_SCOREBOARD_EN
    localparam bit SB = 1'b1;
`else
    localparam bit SB = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic [NR-1:0]    req_valid;
    logic [NR-1:0]    req_ready;
    logic [NR*AW-1:0] req_addr;
    logic [NR*DW-1:0] req_data;
    logic             rf_wen;
    logic [AW-1:0]    rf_addr_w;
    logic [DW-1:0]    rf_data_w;
    logic             claim_valid;
    logic [AW-1:0]    claim_addr;
    logic             claim_ready;
    logic [DP-1:0]    busy;

    int vectors     = 0;
    int miscompares = 0;

    logic [AW+DW-1:0] exp_q[$];

    always #5 clk = ~clk;

    regfile_wb_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DP)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_data(req_data),
        .rf_wen(rf_wen), .rf_addr_w(rf_addr_w), .rf_data_w(rf_data_w),
        .claim_valid(claim_valid), .claim_addr(claim_addr), .claim_ready(claim_ready),
        .busy(busy)
    );

    // ---------------- driver tasks ----------------
    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] d;
        for (int w = 0; w < DW/32; w++) d[w*32 +: 32] = $urandom();
        return d;
    endfunction

    task automatic set_req(input int i, input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid[i]         = v;
        req_addr[i*AW +: AW] = a;
        req_data[i*DW +: DW] = d;
    endtask

    task automatic idle();
        req_valid   = '0;
        claim_valid = 1'b0;
    endtask

    // Advance one clock; returns 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [DW-1:0] d0;
        d0 = rand_data();
        rst = 1'b1;
        set_req(0, 1'b1, 5'd1, d0);
        set_req(1, 1'b1, 5'd2, rand_data());
        set_req(2, 1'b1, 5'd3, rand_data());
        claim_valid = 1'b1;
        claim_addr  = 5'd4;
        for (int c = 0; c < 2; c++) begin
            step();
            vectors++;
            if (req_ready !== 3'b000) begin
                miscompares++;
                $display("FAIL reset_req_ready: got %b expected 000", req_ready);
            end
            vectors++;
            if (claim_ready !== !SB) begin
                miscompares++;
                $display("FAIL reset_claim_ready: got %b expected %b", claim_ready, !SB);
            end
            vectors++;
            if (rf_wen !== 1'b0 || rf_addr_w !== '0 || rf_data_w !== '0) begin
                miscompares++;
                $display("FAIL reset_outputs: got wen=%b addr=%0d expected wen=0 addr=0 data=0", rf_wen, rf_addr_w);
            end
            vectors++;
            if (busy !== '0) begin
                miscompares++;
                $display("FAIL reset_busy: got %h expected 0", busy);
            end
        end
        rst = 1'b0;
        claim_valid = 1'b0;
        #1;
        vectors++;
        if (req_ready !== 3'b001) begin
            miscompares++;
            $display("FAIL reset_first_grant: got %b expected 001", req_ready);
        end
        step();
        idle();
        vectors++;
        if (rf_wen !== 1'b1 || rf_addr_w !== 5'd1 || rf_data_w !== d0) begin
            miscompares++;
            $display("FAIL reset_first_write: got wen=%b addr=%0d expected wen=1 addr=1", rf_wen, rf_addr_w);
        end
        step();
    endtask

    task automatic test_round_robin();
        logic [DW-1:0] d[NR];
        do_reset();
        for (int i = 0; i < NR; i++) begin
            d[i] = rand_data();
            set_req(i, 1'b1, AW'(10 + i), d[i]);
        end
        for (int c = 0; c < 6; c++) begin
            #1;
            vectors++;
            if (req_ready !== 3'(1 << (c % NR))) begin
                miscompares++;
                $display("FAIL rr_grant[%0d]: got %b expected %b", c, req_ready, 3'(1 << (c % NR)));
            end
            step();
            vectors++;
            if (rf_wen !== 1'b1 || rf_addr_w !== AW'(10 + c % NR) || rf_data_w !== d[c % NR]) begin
                miscompares++;
                $display("FAIL rr_write[%0d]: got wen=%b addr=%0d expected wen=1 addr=%0d", c, rf_wen, rf_addr_w, 10 + c % NR);
            end
        end
        idle();
        step();
        vectors++;
        if (rf_wen !== 1'b0 || rf_addr_w !== 5'd12 || rf_data_w !== d[2]) begin
            miscompares++;
            $display("FAIL rr_hold: got wen=%b addr=%0d expected wen=0 addr=12", rf_wen, rf_addr_w);
        end
    endtask

    task automatic test_single();
        logic [DW-1:0] a5;
        a5 = {(DW/8){8'hA5}};
        do_reset();
        set_req(2, 1'b1, 5'd17, a5);
        #1;
        vectors++;
        if (req_ready !== 3'b100) begin
            miscompares++;
            $display("FAIL single_grant: got %b expected 100", req_ready);
        end
        step();
        idle();
        vectors++;
        if (rf_wen !== 1'b1 || rf_addr_w !== 5'd17 || rf_data_w !== a5) begin
            miscompares++;
            $display("FAIL single_write: got wen=%b addr=%0d data=%h expected wen=1 addr=17", rf_wen, rf_addr_w, rf_data_w);
        end
        step();
        vectors++;
        if (rf_wen !== 1'b0 || rf_data_w !== a5) begin
            miscompares++;
            $display("FAIL single_idle: got wen=%b expected wen=0 with data held", rf_wen);
        end
    endtask

    task automatic test_hazard();
        do_reset();
        claim_valid = 1'b1;
        claim_addr  = 5'd4;
        #1;
        vectors++;
        if (claim_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL hazard_claim0: got %b expected 1", claim_ready);
        end
        step();
        vectors++;
        if (busy[4] !== SB) begin
            miscompares++;
            $display("FAIL hazard_busy_set: got %b expected %b", busy[4], SB);
        end
        #1;
        vectors++;
        if (claim_ready !== !SB) begin
            miscompares++;
            $display("FAIL hazard_claim1: got %b expected %b", claim_ready, !SB);
        end
        claim_valid = 1'b0;
        step();
        step();
        set_req(0, 1'b1, 5'd4, rand_data());
        #1;
        vectors++;
        if (req_ready !== 3'b001 || busy[4] !== SB) begin
            miscompares++;
            $display("FAIL hazard_wb_accept: got ready=%b busy4=%b expected ready=001 busy4=%b", req_ready, busy[4], SB);
        end
        step();
        idle();
        vectors++;
        if (busy !== '0 || rf_wen !== 1'b1 || rf_addr_w !== 5'd4) begin
            miscompares++;
            $display("FAIL hazard_clear: got busy=%h wen=%b addr=%0d expected busy=0 wen=1 addr=4", busy, rf_wen, rf_addr_w);
        end
    endtask

    task automatic test_collision();
        do_reset();
        set_req(1, 1'b1, 5'd9, rand_data());
        claim_valid = 1'b1;
        claim_addr  = 5'd9;
        #1;
        vectors++;
        if (req_ready !== 3'b010 || claim_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL collide_accept: got ready=%b claim_ready=%b expected 010 and 1", req_ready, claim_ready);
        end
        step();
        idle();
        vectors++;
        if (busy[9] !== SB || rf_wen !== 1'b1 || rf_addr_w !== 5'd9) begin
            miscompares++;
            $display("FAIL collide_set_wins: got busy9=%b wen=%b addr=%0d expected busy9=%b", busy[9], rf_wen, rf_addr_w, SB);
        end
        set_req(0, 1'b1, 5'd0, rand_data());
        step();
        idle();
        vectors++;
        if (busy[9] !== SB || rf_wen !== 1'b1 || rf_addr_w !== 5'd0) begin
            miscompares++;
            $display("FAIL collide_addr0: got busy9=%b wen=%b addr=%0d expected busy9=%b addr=0", busy[9], rf_wen, rf_addr_w, SB);
        end
    endtask

    // Randomized run; the model picks the first valid requester at or after m_ptr, modulo NR.
    task automatic test_back_to_back_random();
        int            m_ptr;
        logic [DP-1:0] m_busy;
        int            g;
        logic [NR-1:0] exp_rdy;
        logic          exp_cr;
        logic [AW-1:0] ga;
        logic [DW-1:0] gd;
        logic [AW+DW-1:0] item;
        do_reset();
        m_ptr  = 0;
        m_busy = '0;
        exp_q.delete();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NR; i++)
                set_req(i, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), rand_data());
            claim_valid = 1'($urandom_range(0, 1));
            claim_addr  = AW'($urandom_range(0, 7));
            g = -1;
            for (int k = 0; k < NR; k++)
                if (g < 0 && req_valid[(m_ptr + k) % NR]) g = (m_ptr + k) % NR;
            exp_rdy = (g >= 0) ? NR'(1 << g) : '0;
            exp_cr  = SB ? !m_busy[claim_addr] : 1'b1;
            #1;
            vectors++;
            if (req_ready !== exp_rdy) begin
                miscompares++;
                $display("FAIL rand_ready[%0d]: got %b expected %b", c, req_ready, exp_rdy);
            end
            vectors++;
            if (claim_ready !== exp_cr) begin
                miscompares++;
                $display("FAIL rand_claim_ready[%0d]: got %b expected %b", c, claim_ready, exp_cr);
            end
            if (g >= 0) begin
                ga = req_addr[g*AW +: AW];
                gd = req_data[g*DW +: DW];
                exp_q.push_back({ga, gd});
                m_ptr = (g + 1) % NR;
                if (SB) m_busy[ga] = 1'b0;
            end
            if (SB && claim_valid && exp_cr) m_busy[claim_addr] = 1'b1;
            step();
            vectors++;
            if (rf_wen === 1'b1) begin
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL rand_write[%0d]: got unexpected write addr=%0d expected none", c, rf_addr_w);
                end else begin
                    item = exp_q.pop_front();
                    if ({rf_addr_w, rf_data_w} !== item) begin
                        miscompares++;
                        $display("FAIL rand_write[%0d]: got addr=%0d expected addr=%0d (or data differs)", c, rf_addr_w, item[AW+DW-1:DW]);
                    end
                end
            end else if (rf_wen !== 1'b0 || exp_q.size() != 0) begin
                miscompares++;
                $display("FAIL rand_write[%0d]: got wen=%b expected wen=%0d", c, rf_wen, exp_q.size());
                exp_q.delete();
            end
            vectors++;
            if (busy !== m_busy) begin
                miscompares++;
                $display("FAIL rand_busy[%0d]: got %h expected %h", c, busy, m_busy);
            end
        end
        idle();
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_addr  = '0;
        req_data  = '0;
        claim_valid = 1'b0;
        claim_addr  = '0;
        step();
        test_reset();
        test_round_robin();
        test_single();
        test_hazard();
        test_collision();
        test_back_to_back_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-back arbiter and register scoreboard for the 32-entry, 512-bit vector register file. It shares the register file's single write port between `NUM_REQ` write-back requesters (vector FMA, matrix unit, load/DMA) using round-robin arbitration and drives `wen/addr_w/data_w` from a registered output stage. It also tracks which registers have an outstanding write so the issue logic can stall on RAW/WAW hazards.

## Interface
- `NUM_REQ`, 3: number of write-back requesters (2..4).
- `DATA_WIDTH`, 512: vector width.
- `ADDR_WIDTH`, 5: register address width.
- `DEPTH`, 32: number of registers.

Ports:
- `clk` in 1: clock; all state updates on posedge.
- `rst` in 1: reset, synchronous, active-high.
- `req_valid` in NUM_REQ: requester i has a write pending.
- `req_ready` out NUM_REQ: grant; the handshake completes when `req_valid[i] & req_ready[i]`.
- `req_addr` in NUM_REQ*ADDR_WIDTH: destination address, requester i at slice i.
- `req_data` in NUM_REQ*DATA_WIDTH: write data, requester i at slice i.
- `rf_wen` out 1: register-file write enable.
- `rf_addr_w` out ADDR_WIDTH: register-file write address.
- `rf_data_w` out DATA_WIDTH: register-file write data.
- `claim_valid` in 1: issue logic reserves destination `claim_addr`.
- `claim_addr` in ADDR_WIDTH: register being reserved.
- `claim_ready` out 1: reservation accepted (destination not busy).
- `busy` out DEPTH: per-register outstanding-write flags.

## Operation
- **Arbitration**
  - Round-robin pointer `ptr` in 0..NUM_REQ-1.
  - Grant goes to the first `i` with `req_valid[i]` set, searching from `ptr` upward with wrap.
  - `req_ready` is combinational, one-hot or zero, and never asserted without the matching `req_valid`.
  - The write port never stalls, so at most one handshake completes each cycle and a lone requester is always granted.
  - On a handshake by requester `i`, `ptr <= (i+1) mod NUM_REQ`. With no handshake, `ptr` holds.
- **Output stage**
  - On a handshake, `rf_wen <= 1`, `rf_addr_w <= req_addr[i]`, `rf_data_w <= req_data[i]`.
  - With no handshake, `rf_wen <= 0` and addr/data hold their last values.
  - Address 0 is writable; there is no special casing.
- **Scoreboard**
  - `claim_ready = ~busy[claim_addr]`, combinational from registered `busy` only (no bypass).
  - Set: `claim_valid & claim_ready` sets `busy[claim_addr]`.
  - Clear: a write-back handshake clears `busy[req_addr[i]]` at the accept edge.
  - Same register set and cleared in the same cycle: set wins, so the bit ends at 1.
  - A write-back to a non-busy register is legal; its bit stays 0.
- **Reset**
  - Values: `rf_wen=0`, `rf_addr_w=0`, `rf_data_w=0`, `busy=0`, `ptr=0`.
  - `req_ready` and `claim_ready` reflect the reset state combinationally. During reset cycles both are forced to 0.
  - Reset mid-operation drops any write registered but not yet presented. Requesters must re-issue.

## Timing
- Handshake on edge N: `rf_wen=1` with addr/data during cycle N+1. The register file commits at edge N+1.
- `busy` drops in cycle N+1, the same cycle `rf_wen` is high. A consumer reading then gets the value through the register file's write-through forwarding.
- Claim accepted at edge N: `busy` is high from cycle N+1. A second claim to the same register in cycle N+1 sees `claim_ready=0`.
- Back-to-back handshakes give `rf_wen` high on consecutive cycles, one write per cycle.
- Throughput: one write per cycle. Worst-case wait for requester `i` with `req_valid` held is NUM_REQ-1 cycles.

## Configuration
- `RF_WB_SCOREBOARD_EN`
  - Defined: scoreboard implemented exactly as above.
  - Undefined: no busy state is synthesized, `busy` is tied to 0, and `claim_ready` is tied to 1. Arbitration and the output stage are unchanged.

## Test plan
- **Reset:** hold `rst=1` for 2 cycles with all requesters valid → `req_ready=0`, `rf_wen=0`, `busy=0`. After release, requester 0 is granted first.
- **Round-robin:** all 3 valid continuously for 6 cycles → grant order 0,1,2,0,1,2. `rf_addr_w` follows each requester's address one cycle later, and `rf_wen` stays high for 6 cycles.
- **Single requester:** only requester 2 valid with addr 17 and data `0xA5..A5` → `req_ready[2]=1` the same cycle. Next cycle `rf_wen=1`, `rf_addr_w=17`, `rf_data_w=0xA5..A5`.
- **Scoreboard hazard:** claim addr 4 at cycle 0 → `busy[4]=1` from cycle 1, and a claim of 4 in cycle 1 gets `claim_ready=0`. Write-back to 4 accepted at cycle 3 → `busy[4]=0` in cycle 4, where `rf_wen=1`, `rf_addr_w=4`.
- **Set/clear collision:** in one cycle, claim addr 9 while a write-back to 9 (not busy) is accepted → `busy[9]=1` afterwards.
- **Macro off:** rebuild without `RF_WB_SCOREBOARD_EN` and repeat the hazard scenario → `claim_ready=1` and `busy=0` throughout, with write sequencing identical.
